fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Multicycle instruction-fetch sequencer for the single-issue MIPS datapath. It owns the instruction address pointer and requests instructions from instruction memory over a req/ack handshake. It presents each fetched word to the decoder with a valid/stall handshake and advances the pointer by one word, or redirects it to a branch target, as each instruction is consumed. It also stops at a programmed last address and counts retired instructions.

Parameters:
W, 6, instruction address width in words; the pointer wraps modulo 2^W.
IW, 32, instruction word width.
LAST_ADDR, 2^W-1, address whose sequential consumption ends the program (enter HALT).

Ports:
clk  in  1  clock; all state changes on rising edge.
clr_n  in  1  reset, asynchronous assert, active-low; synchronous deassert is provided externally.
start  in  1  one-cycle pulse; begins fetching at address 0 from IDLE or HALT.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  W  fetch address, equal to the current pc.
imem_ack  in  1  memory response; imem_rdata is valid in the same cycle.
imem_rdata  in  IW  instruction word from memory.
instr  out  IW  captured instruction presented to the decoder.
instr_valid  out  1  instr is valid and awaiting consumption.
stall  in  1  decoder/hazard unit cannot consume instr this cycle.
br_valid  in  1  the instruction being consumed redirects the pc.
br_target  in  W  redirect address.
pc  out  W  current instruction address.
busy  out  1  high in FETCH or ISSUE.
halted  out  1  high in HALT.
icount  out  16  retired-instruction count; saturates at 16'hFFFF.

Behaviour:
- Reset (clr_n=0, any time, including mid-handshake): state=IDLE; pc=0, instr=0, icount=0; imem_req, instr_valid, busy and halted are all 0. Takes effect without a clock edge.
- Outputs are decoded from registered state (Moore). imem_addr always equals pc.
- IDLE: all outputs idle. start=1 -> FETCH, pc=0, icount=0.
- FETCH: imem_req=1. The request is held, with imem_addr stable, until imem_ack=1. On an ack edge: instr<=imem_rdata, -> ISSUE. Zero-wait memory (ack in the first FETCH cycle) gives 1 FETCH cycle + 1 ISSUE cycle minimum per instruction.
- ISSUE: instr_valid=1, imem_req=0; instr is held while stall=1.
- ISSUE, consume (stall=0):
  - icount increments; it holds at 16'hFFFF.
  - If br_valid=1: pc<=br_target, -> FETCH. A branch is never halted, even when pc==LAST_ADDR.
  - Else if pc==LAST_ADDR: pc is unchanged, -> HALT.
  - Else: pc<=pc+1 modulo 2^W, -> FETCH.
- br_valid and br_target are sampled only on the ISSUE consume edge and are ignored in all other states and while stall=1.
- HALT: halted=1, pc retains LAST_ADDR. start=1 -> FETCH, pc=0, icount=0.
- start is ignored in FETCH and ISSUE. imem_ack outside FETCH is ignored and instr does not change.
- busy=1 in FETCH and ISSUE.
- State encoding: 2 bits (IDLE, FETCH, ISSUE, HALT). No unreachable-state lockup: any illegal encoding returns to IDLE.

Test Plan:
- Reset/idle: clr_n=0 asserted mid-cycle -> all outputs 0 immediately. Release and hold 5 cycles without start -> state stays IDLE, imem_req=0.
- Sequential fetch, zero-wait memory (ack in the same cycle as req), stall=0, W=6, LAST_ADDR=3: start -> imem_addr sequence 0,1,2,3 at 2 cycles per instruction; halted=1 after 4th consume; icount=4; pc=3.
- Wait states: ack delayed 3 cycles at addr 0 -> imem_req and imem_addr=0 held for 3 FETCH cycles; instr captures rdata only on the ack cycle (e.g. 32'h8C010004).
- Stall + branch: in ISSUE at pc=5, hold stall=1 with br_valid=1, br_target=20 for 4 cycles -> instr_valid stays 1 and pc stays 5. Drop stall -> pc=20, next imem_addr=20, icount +1 once.
- Wrap and branch at LAST_ADDR: LAST_ADDR=62, branch to 63, consume 63 sequentially -> pc wraps to 0, no halt. Separately, br_valid at pc=62 -> goes to target, not HALT.
- Reset mid-operation and restart: clr_n pulsed during FETCH with imem_req=1 -> IDLE, imem_req=0 immediately. From HALT, start -> FETCH at pc=0 with icount cleared.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Multicycle instruction-fetch sequencer: owns the pc, fetches over req/ack,
// issues to the decoder with valid/stall, and stops at a programmed last address.
module fetch_ctrl #(
  parameter int unsigned W         = 6,
  parameter int unsigned IW        = 32,
  parameter int unsigned LAST_ADDR = (1 << W) - 1
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          start,
  output logic          imem_req,
  output logic [W-1:0]  imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          stall,
  input  logic          br_valid,
  input  logic [W-1:0]  br_target,
  output logic [W-1:0]  pc,
  output logic          busy,
  output logic          halted,
  output logic [15:0]   icount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_ISSUE = 2'b10,
    S_HALT  = 2'b11
  } state_e;

  localparam logic [W-1:0] LAST = W'(LAST_ADDR);
  localparam logic [W-1:0] ONE  = W'(1);

  state_e        state_q, state_d;
  logic [W-1:0]  pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [15:0]   icnt_q, icnt_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      icnt_q  <= icnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    icnt_d  = icnt_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          icnt_d  = '0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          if (icnt_q != 16'hFFFF)
            icnt_d = icnt_q + 16'd1;
          // A taken branch wins over the end-of-program check.
          if (br_valid) begin
            pc_d    = br_target;
            state_d = S_FETCH;
          end else if (pc_q == LAST) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + ONE;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_ISSUE);
  assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALT);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign icount      = icnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: one instance with LAST_ADDR=3 (a_*),
// one with LAST_ADDR=62 (b_*), sharing clock and reset.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_start = 0, a_ack = 0, a_stall = 0, a_brv = 0;
  logic [31:0] a_rdata = 0;
  logic [5:0]  a_brt = 0;
  logic        a_req, a_iv, a_busy, a_halted;
  logic [5:0]  a_addr, a_pc;
  logic [31:0] a_instr;
  logic [15:0] a_icnt;

  logic        b_start = 0, b_ack = 0, b_stall = 0, b_brv = 0;
  logic [31:0] b_rdata = 0;
  logic [5:0]  b_brt = 0;
  logic        b_req, b_iv, b_busy, b_halted;
  logic [5:0]  b_addr, b_pc;
  logic [31:0] b_instr;
  logic [15:0] b_icnt;

  int nerr = 0;
  int nchk = 0;

  fetch_ctrl #(.W(6), .IW(32), .LAST_ADDR(3)) u_a (
    .clk(clk), .clr_n(clr_n), .start(a_start),
    .imem_req(a_req), .imem_addr(a_addr),
    .imem_ack(a_ack), .imem_rdata(a_rdata),
    .instr(a_instr), .instr_valid(a_iv), .stall(a_stall),
    .br_valid(a_brv), .br_target(a_brt), .pc(a_pc),
    .busy(a_busy), .halted(a_halted), .icount(a_icnt)
  );

  fetch_ctrl #(.W(6), .IW(32), .LAST_ADDR(62)) u_b (
    .clk(clk), .clr_n(clr_n), .start(b_start),
    .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(b_ack), .imem_rdata(b_rdata),
    .instr(b_instr), .instr_valid(b_iv), .stall(b_stall),
    .br_valid(b_brv), .br_target(b_brt), .pc(b_pc),
    .busy(b_busy), .halted(b_halted), .icount(b_icnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state, checked while clr_n is low
    #12;
    chk("rst_req", a_req, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_halt", a_halted, 0);
    chk("rst_iv", a_iv, 0);
    chk("rst_pc", a_pc, 0);
    chk("rst_icnt", a_icnt, 0);
    chk("rst_instr", a_instr, 0);
    clr_n = 1;
    repeat (5) tick();
    chk("idle_req", a_req, 0);
    chk("idle_busy", a_busy, 0);
    chk("idle_b_busy", b_busy, 0);

    // zero-wait sequential run to LAST_ADDR=3
    a_start = 1;
    tick();
    a_start = 0;
    for (int i = 0; i < 4; i++) begin
      chk("seq_req", a_req, 1);
      chk("seq_addr", a_addr, i);
      a_ack = 1;
      a_rdata = 32'h1000 + i;
      tick();
      a_ack = 0;
      chk("seq_iv", a_iv, 1);
      chk("seq_instr", a_instr, 32'h1000 + i);
      chk("seq_req_lo", a_req, 0);
      tick();
    end
    chk("seq_halted", a_halted, 1);
    chk("seq_busy", a_busy, 0);
    chk("seq_icnt", a_icnt, 4);
    chk("seq_pc", a_pc, 3);
    a_ack = 1;
    a_rdata = 32'hDEADBEEF;
    tick();
    a_ack = 0;
    chk("halt_ack_ign", a_instr, 32'h1003);
    chk("halt_stay", a_halted, 1);

    // wait states on instance b
    b_start = 1;
    tick();
    b_start = 0;
    for (int k = 0; k < 3; k++) begin
      chk("ws_req", b_req, 1);
      chk("ws_addr", b_addr, 0);
      chk("ws_iv", b_iv, 0);
      chk("ws_instr", b_instr, 0);
      b_rdata = 32'hBAD0 + k;
      tick();
    end
    chk("ws_req_held", b_req, 1);
    b_ack = 1;
    b_rdata = 32'h8C010004;
    tick();
    b_ack = 0;
    b_rdata = 0;
    chk("ws_iv_on", b_iv, 1);
    chk("ws_capture", b_instr, 32'h8C010004);

    // advance to pc=5
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk("adv_addr", b_addr, j);
      b_ack = 1;
      tick();
      b_ack = 0;
    end
    chk("adv_iv", b_iv, 1);
    chk("adv_icnt", b_icnt, 5);

    // stall with a pending branch
    b_stall = 1;
    b_brv = 1;
    b_brt = 20;
    repeat (4) begin
      tick();
      chk("stall_iv", b_iv, 1);
      chk("stall_pc", b_pc, 5);
    end
    chk("stall_icnt", b_icnt, 5);
    b_stall = 0;
    tick();
    b_brv = 0;
    chk("br_pc", b_pc, 20);
    chk("br_addr", b_addr, 20);
    chk("br_req", b_req, 1);
    chk("br_icnt", b_icnt, 6);

    // branch at LAST_ADDR, then wrap from 63
    b_ack = 1; tick(); b_ack = 0;
    b_brv = 1; b_brt = 62; tick(); b_brv = 0;
    chk("to62_pc", b_pc, 62);
    b_ack = 1; tick(); b_ack = 0;
    b_brv = 1; b_brt = 63; tick(); b_brv = 0;
    chk("br_last_pc", b_pc, 63);
    chk("br_last_nohalt", b_halted, 0);
    chk("br_last_req", b_req, 1);
    b_ack = 1; tick(); b_ack = 0;
    tick();
    chk("wrap_pc", b_pc, 0);
    chk("wrap_nohalt", b_halted, 0);
    chk("wrap_icnt", b_icnt, 9);

    // sequential consume of 62 halts
    b_ack = 1; tick(); b_ack = 0;
    b_brv = 1; b_brt = 62; tick(); b_brv = 0;
    b_ack = 1; tick(); b_ack = 0;
    tick();
    chk("b_halted", b_halted, 1);
    chk("b_halt_pc", b_pc, 62);
    chk("b_halt_icnt", b_icnt, 11);

    // restart a from HALT
    a_start = 1;
    tick();
    a_start = 0;
    chk("rs_halt", a_halted, 0);
    chk("rs_req", a_req, 1);
    chk("rs_pc", a_pc, 0);
    chk("rs_icnt", a_icnt, 0);
    a_start = 1;
    tick();
    a_start = 0;
    chk("rs_start_ign", a_req, 1);

    // asynchronous reset during FETCH
    #2;
    clr_n = 0;
    #1;
    chk("ar_req", a_req, 0);
    chk("ar_busy", a_busy, 0);
    chk("ar_instr", a_instr, 0);
    chk("ar_b_halt", b_halted, 0);
    chk("ar_b_pc", b_pc, 0);
    clr_n = 1;
    tick();
    chk("ar_idle", a_busy, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
